mem_stage: RTL and testbench

- Consumer end of the execute-stage output interface in the 32-bit pipelined RISC-V core.
- Registers the EX results (EX/MEM register) and performs word loads/stores over a variable-latency request/acknowledge data-memory port.
- Resolves branches and produces the registered MEM/WB bundle for writeback.
- Stalls upstream while a memory access is outstanding.

---
 rtl/core_pkg.sv | 46 ++++
 rtl/mem_access_fsm.sv | 98 +++++++++
 rtl/mem_stage.sv | 138 +++++++++++++
 tb/tb_mem_stage.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: control-bit indices, MEM-stage FSM encoding and pipeline bundles.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package core_pkg;

   // Bundle datapath width; mem_stage Width must match this value.
   localparam int XLEN = 32;

   // Bit positions inside the 6-bit controlSignal bus (bit 5, ALUSrc, is consumed in EX).
   localparam int CS_MEMTOREG = 4;
   localparam int CS_REGWRITE = 3;
   localparam int CS_MEMREAD  = 2;
   localparam int CS_MEMWRITE = 1;
   localparam int CS_BRANCH   = 0;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } mem_state_e;

   // EX/MEM pipeline register contents.
   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] alu;
      logic [XLEN-1:0] adder;
      logic [XLEN-1:0] wdata;
      logic [4:0]      rd;
      logic            memtoreg;
      logic            regwrite;
      logic            memread;
      logic            memwrite;
      logic            branch;
      logic            zero;
   } exmem_t;

   // MEM/WB pipeline register contents.
   typedef struct packed {
      logic            valid;
      logic            regwrite;
      logic            memtoreg;
      logic [XLEN-1:0] rdata;
      logic [XLEN-1:0] alu;
      logic [4:0]      rd;
   } memwb_t;

endpackage

// File: rtl/mem_access_fsm.sv
// Data-memory access sequencer: IDLE/WAIT FSM, timeout counter, dmem handshake, stall.
// Latency: request rises the cycle after capture; completes on the ack edge or after TIMEOUT WAIT cycles.
// Backpressure: stall is high in WAIT until ack (also high on the timeout cycle).
import core_pkg::*;

module mem_access_fsm #(
   parameter int Width   = 32,
   parameter int TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ex_valid,
   input  logic             mem_op,
   input  logic [1:0]       addr_low,
   input  logic             st_memwrite,
   input  logic [Width-1:0] st_addr,
   input  logic [Width-1:0] st_wdata,
   input  logic             dmem_ack,
   output logic             stall,
   output logic             wait_state,
   output logic             acc_done,
   output logic             acc_timeout,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic [Width-1:0] dmem_addr,
   output logic [Width-1:0] dmem_wdata,
   output logic             misalign_err,
   output logic             timeout_err
);

   localparam int CW = $clog2(TIMEOUT + 1);

   mem_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          mis_err_q, mis_err_d;
   logic          to_err_q, to_err_d;
   logic          start;
   logic          misalign;

   // Next state, timeout counter, sticky flags and handshake qualifiers.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      wait_state  = (state_q == WAIT);
      stall       = wait_state & ~dmem_ack;
      acc_done    = wait_state & dmem_ack;
      acc_timeout = stall & (cnt_q == CW'(TIMEOUT - 1));
      // A new instruction is captured whenever stall is low.
      start       = ~stall & ex_valid & mem_op & (addr_low == 2'b00);
      misalign    = ~stall & ex_valid & mem_op & (addr_low != 2'b00);
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = WAIT;
               cnt_d   = '0;
            end
         end
         WAIT: begin
            if (dmem_ack) begin
               // Completion and a back-to-back capture can share the edge.
               state_d = start ? WAIT : IDLE;
               cnt_d   = '0;
            end else if (acc_timeout) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      mis_err_d = mis_err_q | misalign;
      to_err_d  = to_err_q | acc_timeout;
   end

   // State, counter and sticky error registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         mis_err_q <= 1'b0;
         to_err_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         mis_err_q <= mis_err_d;
         to_err_q  <= to_err_d;
      end
   end

   // Request fields come straight from the held EX/MEM register, so they stay stable until ack.
   assign dmem_req     = wait_state;
   assign dmem_we      = wait_state & st_memwrite;
   assign dmem_addr    = st_addr;
   assign dmem_wdata   = st_wdata;
   assign misalign_err = mis_err_q;
   assign timeout_err  = to_err_q;

endmodule

// File: rtl/mem_stage.sv
// MEM stage: EX/MEM register, branch resolution, word load/store via mem_access_fsm, MEM/WB register.
// Latency: 1 cycle for non-memory ops; memory ops retire on the ack edge (or on timeout).
// Backpressure: stall holds upstream and the EX/MEM register while an access is outstanding.
import core_pkg::*;

module mem_stage #(
   parameter int Width   = 32,
   parameter int TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             exValid,
   input  logic [Width-1:0] ALUResult,
   input  logic [Width-1:0] adderResult,
   input  logic [Width-1:0] ReadData2,
   input  logic [4:0]       rd0,
   input  logic [5:0]       controlSignal,
   input  logic             zero,
   output logic             stall,
   output logic             pcSrc,
   output logic [Width-1:0] branchTarget,
   output logic             flush,
   output logic             dmemReq,
   output logic             dmemWe,
   output logic [Width-1:0] dmemAddr,
   output logic [Width-1:0] dmemWdata,
   input  logic [Width-1:0] dmemRdata,
   input  logic             dmemAck,
   output logic             wbValid,
   output logic             wbRegWrite,
   output logic             wbMemToReg,
   output logic [Width-1:0] wbReadData,
   output logic [Width-1:0] wbALUResult,
   output logic [4:0]       wbRd,
   output logic             misalignErr,
   output logic             timeoutErr
);

   exmem_t ex_q, ex_d;
   memwb_t wb_q, wb_d;
   logic   wait_state;
   logic   acc_done;
   logic   acc_timeout;
   logic   ex_misalign;
   logic   retire;
   logic   unused_alusrc;

   // ALUSrc has already been consumed by the execute stage.
   assign unused_alusrc = controlSignal[5];

   mem_access_fsm #(
      .Width   (Width),
      .TIMEOUT (TIMEOUT)
   ) u_fsm (
      .clk          (clk),
      .rst          (rst),
      .ex_valid     (exValid),
      .mem_op       (controlSignal[CS_MEMREAD] | controlSignal[CS_MEMWRITE]),
      .addr_low     (ALUResult[1:0]),
      .st_memwrite  (ex_q.memwrite),
      .st_addr      (ex_q.alu),
      .st_wdata     (ex_q.wdata),
      .dmem_ack     (dmemAck),
      .stall        (stall),
      .wait_state   (wait_state),
      .acc_done     (acc_done),
      .acc_timeout  (acc_timeout),
      .dmem_req     (dmemReq),
      .dmem_we      (dmemWe),
      .dmem_addr    (dmemAddr),
      .dmem_wdata   (dmemWdata),
      .misalign_err (misalignErr),
      .timeout_err  (timeoutErr)
   );

   // EX/MEM capture; a timed-out access is dropped so it cannot retire a second time.
   always_comb begin
      ex_d = ex_q;
      if (!stall) begin
         ex_d.valid    = exValid;
         ex_d.alu      = ALUResult;
         ex_d.adder    = adderResult;
         ex_d.wdata    = ReadData2;
         ex_d.rd       = rd0;
         ex_d.memtoreg = controlSignal[CS_MEMTOREG];
         ex_d.regwrite = controlSignal[CS_REGWRITE];
         ex_d.memread  = controlSignal[CS_MEMREAD];
         ex_d.memwrite = controlSignal[CS_MEMWRITE];
         ex_d.branch   = controlSignal[CS_BRANCH];
         ex_d.zero     = zero;
      end else if (acc_timeout) begin
         ex_d.valid = 1'b0;
      end
   end

   // MEM/WB load on retire; otherwise only the valid/write-enable bits clear.
   always_comb begin
      wb_d          = wb_q;
      wb_d.valid    = 1'b0;
      wb_d.regwrite = 1'b0;
      ex_misalign   = (ex_q.memread | ex_q.memwrite) & (ex_q.alu[1:0] != 2'b00);
      // In IDLE a valid EX/MEM entry is always a non-memory or misaligned op.
      retire        = (~wait_state & ex_q.valid) | acc_done | acc_timeout;
      if (retire) begin
         wb_d.valid    = 1'b1;
         wb_d.regwrite = ex_q.regwrite & ~ex_q.branch & ~ex_q.memwrite
                         & ~ex_misalign & ~acc_timeout;
         wb_d.memtoreg = ex_q.memtoreg;
         wb_d.alu      = ex_q.alu;
         wb_d.rd       = ex_q.rd;
         if (acc_done && ex_q.memread && !ex_q.memwrite) begin
            wb_d.rdata = dmemRdata;
         end
      end
   end

   // Pipeline registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q <= '0;
         wb_q <= '0;
      end else begin
         ex_q <= ex_d;
         wb_q <= wb_d;
      end
   end

   assign pcSrc        = ex_q.valid & ex_q.branch & ex_q.zero;
   assign flush        = pcSrc;
   assign branchTarget = ex_q.adder;
   assign wbValid      = wb_q.valid;
   assign wbRegWrite   = wb_q.regwrite;
   assign wbMemToReg   = wb_q.memtoreg;
   assign wbReadData   = wb_q.rdata;
   assign wbALUResult  = wb_q.alu;
   assign wbRd         = wb_q.rd;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU, load, store, branch, misalign, timeout and reset-in-WAIT.
// Latency: n/a.
// Backpressure: the bench plays the data-memory side and drives dmemAck directly.
module tb_mem_stage;

   localparam logic [5:0] CS_ALU    = 6'b001000;
   localparam logic [5:0] CS_LOAD   = 6'b011100;
   localparam logic [5:0] CS_STORE  = 6'b000010;
   localparam logic [5:0] CS_BRANCH = 6'b000001;

   logic        clk = 1'b0;
   logic        rst;
   logic        exValid;
   logic [31:0] ALUResult, adderResult, ReadData2;
   logic [4:0]  rd0;
   logic [5:0]  controlSignal;
   logic        zero;
   logic        stall, pcSrc, flush, dmemReq, dmemWe;
   logic [31:0] branchTarget, dmemAddr, dmemWdata, dmemRdata;
   logic        dmemAck;
   logic        wbValid, wbRegWrite, wbMemToReg;
   logic [31:0] wbReadData, wbALUResult;
   logic [4:0]  wbRd;
   logic        misalignErr, timeoutErr;

   int checks = 0;
   int errors = 0;
   int req_cnt;
   int stall_cnt;
   int wait_cnt;

   mem_stage #(.Width(32), .TIMEOUT(16)) dut (
      .clk           (clk),
      .rst           (rst),
      .exValid       (exValid),
      .ALUResult     (ALUResult),
      .adderResult   (adderResult),
      .ReadData2     (ReadData2),
      .rd0           (rd0),
      .controlSignal (controlSignal),
      .zero          (zero),
      .stall         (stall),
      .pcSrc         (pcSrc),
      .branchTarget  (branchTarget),
      .flush         (flush),
      .dmemReq       (dmemReq),
      .dmemWe        (dmemWe),
      .dmemAddr      (dmemAddr),
      .dmemWdata     (dmemWdata),
      .dmemRdata     (dmemRdata),
      .dmemAck       (dmemAck),
      .wbValid       (wbValid),
      .wbRegWrite    (wbRegWrite),
      .wbMemToReg    (wbMemToReg),
      .wbReadData    (wbReadData),
      .wbALUResult   (wbALUResult),
      .wbRd          (wbRd),
      .misalignErr   (misalignErr),
      .timeoutErr    (timeoutErr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Advance one edge and stop 1 ns after it, away from the next edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [5:0] cs, input logic [31:0] alu,
                        input logic [31:0] adder, input logic [31:0] wd, input logic [4:0] rd,
                        input logic z);
      exValid       = v;
      controlSignal = cs;
      ALUResult     = alu;
      adderResult   = adder;
      ReadData2     = wd;
      rd0           = rd;
      zero          = z;
   endtask

   task automatic idle_in();
      drive(1'b0, 6'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
   endtask

   initial begin
      rst       = 1'b1;
      dmemAck   = 1'b0;
      dmemRdata = 32'h0;
      idle_in();
      tick();
      tick();
      // Reset state
      check("rst_stall", {31'b0, stall}, 32'd0);
      check("rst_req", {31'b0, dmemReq}, 32'd0);
      check("rst_wbvalid", {31'b0, wbValid}, 32'd0);
      check("rst_pcsrc", {31'b0, pcSrc}, 32'd0);
      check("rst_flags", {30'b0, misalignErr, timeoutErr}, 32'd0);
      check("rst_rdata", wbReadData, 32'h0);
      rst = 1'b0;

      // ALU op: retires one cycle after capture
      drive(1'b1, CS_ALU, 32'h10, 32'h0, 32'h0, 5'd5, 1'b0);
      tick();
      idle_in();
      #1;
      check("alu_stall", {31'b0, stall}, 32'd0);
      check("alu_wb_early", {31'b0, wbValid}, 32'd0);
      tick();
      check("alu_wbvalid", {31'b0, wbValid}, 32'd1);
      check("alu_regwrite", {31'b0, wbRegWrite}, 32'd1);
      check("alu_result", wbALUResult, 32'h10);
      check("alu_rd", {27'b0, wbRd}, 32'd5);
      check("alu_stall2", {31'b0, stall}, 32'd0);
      tick();
      check("alu_wb_clear", {31'b0, wbValid}, 32'd0);

      // Load with ack in the third WAIT cycle
      drive(1'b1, CS_LOAD, 32'h100, 32'h0, 32'h0, 5'd3, 1'b0);
      tick();
      idle_in();
      req_cnt   = 0;
      stall_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         dmemAck   = (i == 2);
         dmemRdata = (i == 2) ? 32'hDEADBEEF : 32'h0;
         #1;
         if (dmemReq) req_cnt++;
         if (stall) stall_cnt++;
         if (i == 0) begin
            check("ld_we", {31'b0, dmemWe}, 32'd0);
            check("ld_addr", dmemAddr, 32'h100);
         end
         tick();
      end
      dmemAck = 1'b0;
      #1;
      check("ld_req_cycles", req_cnt, 32'd3);
      check("ld_stall_cycles", stall_cnt, 32'd2);
      check("ld_wbvalid", {31'b0, wbValid}, 32'd1);
      check("ld_rdata", wbReadData, 32'hDEADBEEF);
      check("ld_memtoreg", {31'b0, wbMemToReg}, 32'd1);
      check("ld_regwrite", {31'b0, wbRegWrite}, 32'd1);
      check("ld_req_off", {31'b0, dmemReq}, 32'd0);

      // Store acked in its first WAIT cycle, ALU op captured on the ack edge
      drive(1'b1, CS_STORE, 32'h200, 32'h0, 32'h12345678, 5'd0, 1'b0);
      tick();
      drive(1'b1, CS_ALU, 32'h33, 32'h0, 32'h0, 5'd7, 1'b0);
      dmemAck = 1'b1;
      #1;
      check("st_req", {31'b0, dmemReq}, 32'd1);
      check("st_we", {31'b0, dmemWe}, 32'd1);
      check("st_addr", dmemAddr, 32'h200);
      check("st_wdata", dmemWdata, 32'h12345678);
      check("st_stall", {31'b0, stall}, 32'd0);
      tick();
      dmemAck = 1'b0;
      idle_in();
      #1;
      check("st_wbvalid", {31'b0, wbValid}, 32'd1);
      check("st_regwrite", {31'b0, wbRegWrite}, 32'd0);
      check("st_req_off", {31'b0, dmemReq}, 32'd0);
      tick();
      check("b2b_wbvalid", {31'b0, wbValid}, 32'd1);
      check("b2b_regwrite", {31'b0, wbRegWrite}, 32'd1);
      check("b2b_result", wbALUResult, 32'h33);
      check("b2b_rd", {27'b0, wbRd}, 32'd7);

      // Taken branch: one-cycle pcSrc/flush
      drive(1'b1, CS_BRANCH, 32'h0, 32'h40, 32'h0, 5'd0, 1'b1);
      tick();
      idle_in();
      #1;
      check("br_pcsrc", {31'b0, pcSrc}, 32'd1);
      check("br_flush", {31'b0, flush}, 32'd1);
      check("br_target", branchTarget, 32'h40);
      tick();
      check("br_pcsrc_drop", {31'b0, pcSrc}, 32'd0);
      check("br_wbvalid", {31'b0, wbValid}, 32'd1);
      check("br_regwrite", {31'b0, wbRegWrite}, 32'd0);

      // Not-taken branch
      drive(1'b1, CS_BRANCH, 32'h0, 32'h40, 32'h0, 5'd0, 1'b0);
      tick();
      idle_in();
      #1;
      check("bnt_pcsrc", {31'b0, pcSrc}, 32'd0);
      check("bnt_flush", {31'b0, flush}, 32'd0);
      tick();

      // Misaligned load: no request, sticky flag, bubble retire
      drive(1'b1, CS_LOAD, 32'h102, 32'h0, 32'h0, 5'd4, 1'b0);
      tick();
      idle_in();
      #1;
      check("mis_req", {31'b0, dmemReq}, 32'd0);
      check("mis_flag", {31'b0, misalignErr}, 32'd1);
      check("mis_stall", {31'b0, stall}, 32'd0);
      tick();
      check("mis_wbvalid", {31'b0, wbValid}, 32'd1);
      check("mis_regwrite", {31'b0, wbRegWrite}, 32'd0);
      check("mis_req2", {31'b0, dmemReq}, 32'd0);

      // Load never acked: abandoned after TIMEOUT WAIT cycles
      drive(1'b1, CS_LOAD, 32'h300, 32'h0, 32'h0, 5'd9, 1'b0);
      tick();
      idle_in();
      #1;
      check("to_flag_early", {31'b0, timeoutErr}, 32'd0);
      wait_cnt = 0;
      while (stall && wait_cnt < 40) begin
         wait_cnt++;
         tick();
         #1;
      end
      check("to_wait_cycles", wait_cnt, 32'd16);
      check("to_flag", {31'b0, timeoutErr}, 32'd1);
      check("to_req_off", {31'b0, dmemReq}, 32'd0);
      check("to_wbvalid", {31'b0, wbValid}, 32'd1);
      check("to_regwrite", {31'b0, wbRegWrite}, 32'd0);
      tick();
      check("to_no_double", {31'b0, wbValid}, 32'd0);

      // Reset asserted in the second WAIT cycle of a load
      drive(1'b1, CS_LOAD, 32'h400, 32'h0, 32'h0, 5'd2, 1'b0);
      tick();
      idle_in();
      tick();
      rst = 1'b1;
      #1;
      check("rw_in_wait", {31'b0, dmemReq}, 32'd1);
      tick();
      rst       = 1'b0;
      dmemAck   = 1'b1;
      dmemRdata = 32'hCAFEF00D;
      #1;
      check("rw_req", {31'b0, dmemReq}, 32'd0);
      check("rw_stall", {31'b0, stall}, 32'd0);
      check("rw_wbvalid", {31'b0, wbValid}, 32'd0);
      check("rw_flags", {30'b0, misalignErr, timeoutErr}, 32'd0);
      tick();
      dmemAck = 1'b0;
      #1;
      check("rw_late_ack_wb", {31'b0, wbValid}, 32'd0);
      check("rw_late_ack_rdata", wbReadData, 32'h0);
      check("rw_late_ack_req", {31'b0, dmemReq}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global guard so a broken DUT can never hang the run.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
      $fatal(1);
   end

endmodule
